// File: rtl/mod_n_counter_pkg.sv
// rtl/mod_n_counter_pkg.sv - default parameters and width helper for mod_n_counter
package mod_n_counter_pkg;

    localparam int MOD_N_DEFAULT        = 6;
    localparam int MOD_N_LENGTH_DEFAULT = 3;

    // Smallest w such that 2**w >= n (at least 1 bit).
    function automatic int min_width(int n);
        min_width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                min_width = i + 1;
            end
        end
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - free-running modulo-N up counter; optional wrap flag under MOD_N_COUNTER_WRAP_EN
module mod_n_counter
    import mod_n_counter_pkg::*;
#(
    parameter int N      = MOD_N_DEFAULT,
    parameter int LENGTH = MOD_N_LENGTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LENGTH-1:0] counter
`ifdef MOD_N_COUNTER_WRAP_EN
    ,
    output logic              wrap
`endif
);

    // Terminal count; the width check below guarantees N-1 fits in LENGTH bits.
    localparam logic [LENGTH-1:0] LAST = LENGTH'(N - 1);

    if (N < 2) begin : g_bad_modulus
        $fatal(1, "mod_n_counter: N must be >= 2");
    end
    if (LENGTH < min_width(N)) begin : g_bad_length
        $fatal(1, "mod_n_counter: LENGTH too small for N");
    end

    // Power-up value keeps the sequence defined even if rst is never seen high.
    logic [LENGTH-1:0] count_r = '0;

    // Count register: reset wins, wrap at N-1, any out-of-range value falls back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (count_r >= LAST) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + 1'b1;
        end
    end

    assign counter = count_r;

`ifdef MOD_N_COUNTER_WRAP_EN
    logic wrap_r = 1'b0;

    // Wrap flag: high only in the cycle where 0 follows a genuine N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= (count_r == LAST);
        end
    end

    assign wrap = wrap_r;
`endif

`ifndef SYNTHESIS
    localparam logic [LENGTH:0] N_EXT = (LENGTH + 1)'(N);

    // Check can be masked while an out-of-range value is deliberately injected.
    wire  chk_en = 1'b1;
    logic seen_edge;

    // Range check on every edge after the first.
    always_ff @(posedge clk) begin
        seen_edge <= 1'b1;
        if (seen_edge && chk_en) begin
            assert ({1'b0, count_r} < N_EXT)
                else $error("mod_n_counter: counter %0d out of range", count_r);
        end
    end
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - self-checking bench for mod_n_counter (N=6, N=2, N=8 instances)
`timescale 1ns/1ps
module tb_mod_n_counter;

    logic       clk;
    logic       rst;
    logic [2:0] c6;
    logic [0:0] c2;
    logic [2:0] c8;
`ifdef MOD_N_COUNTER_WRAP_EN
    logic       w6;
    logic       w2;
    logic       w8;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state: plain integers following the modulo-N rules.
    int e6 = 0;
    int e2 = 0;
    int e8 = 0;
    int ew = 0;

    mod_n_counter #(.N(6), .LENGTH(3)) u6 (
        .clk(clk), .rst(rst), .counter(c6)
`ifdef MOD_N_COUNTER_WRAP_EN
        , .wrap(w6)
`endif
    );

    mod_n_counter #(.N(2), .LENGTH(1)) u2 (
        .clk(clk), .rst(rst), .counter(c2)
`ifdef MOD_N_COUNTER_WRAP_EN
        , .wrap(w2)
`endif
    );

    mod_n_counter #(.N(8), .LENGTH(3)) u8 (
        .clk(clk), .rst(rst), .counter(c8)
`ifdef MOD_N_COUNTER_WRAP_EN
        , .wrap(w8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nxt(int cur, int n);
        return (cur >= 0 && cur < n - 1) ? cur + 1 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    // One rising edge: advance the model with the rst seen at the edge, then settle to negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            e6 = 0; e2 = 0; e8 = 0; ew = 0;
        end else begin
            ew = (e6 == 5) ? 1 : 0;
            e6 = nxt(e6, 6);
            e2 = nxt(e2, 2);
            e8 = nxt(e8, 8);
        end
        @(negedge clk);
    endtask

    task automatic check_all(string tag);
        chk({tag, ".n6"}, 32'(c6), 32'(e6));
        chk({tag, ".n2"}, 32'(c2), 32'(e2));
        chk({tag, ".n8"}, 32'(c8), 32'(e8));
`ifdef MOD_N_COUNTER_WRAP_EN
        chk({tag, ".wrap6"}, 32'(w6), 32'(ew));
`endif
    endtask

    initial begin
        // No-reset start: rst only pulsed between edges.
        rst = 1'b0;
        #1;
        check_all("powerup");
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_all("noreset_run");
        end
        chk("noreset_wrap_to_0", 32'(c6), 32'd0);

        // Reset held two edges, then count.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("reset_hold");
            chk("reset_zero", 32'(c6), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_all("post_reset_seq");
        end

        // Thirteen edges from 0 covering two wraps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_all("wrap_run");
        end

        // Mid-run reset at count 3.
        while (e6 != 3) tick();
        check_all("at3");
        rst = 1'b1;
        tick();
        check_all("midrun_reset");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all("midrun_resume");
        end

        // Out-of-range recovery from 7 and from 6.
        for (int v = 7; v >= 6; v--) begin
            force u6.chk_en = 1'b0;
            force u6.count_r = 3'(v);
            #1;
            release u6.count_r;
            e6 = v;
            tick();
            check_all("recover_first");
            chk("recover_zero", 32'(c6), 32'd0);
            release u6.chk_en;
            tick();
            check_all("recover_next");
        end

        // Randomized rst with occasional assertion.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 9) == 0);
            tick();
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100us");
        $fatal(1, "timeout");
    end

endmodule
